// File: rtl/axil2wb_pkg.sv
// Shared types and helpers for the AXI4-Lite to Wishbone watchdog bridge.
package axil2wb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    BUS,
    WAITACK,
    BRESP,
    RRESP
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Number of byte-offset bits dropped when turning an AXI byte address into a WB word address.
  function automatic int axilLsb(input int dataWidth);
    return $clog2(dataWidth / 8);
  endfunction

endpackage

// File: rtl/axil2wb_watchdog.sv
// Cycle counter that flags a Wishbone cycle which has stayed open too long.
module axil2wb_watchdog #(
  parameter int LGTIMEOUT      = 8,
  parameter int TIMEOUT_CYCLES = 10
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);

  localparam logic [LGTIMEOUT-1:0] LIMIT = LGTIMEOUT'(TIMEOUT_CYCLES - 1);

  logic [LGTIMEOUT-1:0] count_q, count_d;

  // Saturate instead of wrapping so a stuck enable can never re-arm the count.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire_o = enable_i && (count_q == LIMIT);

endmodule

// File: rtl/axil2wb_wdog_bridge.sv
// AXI4-Lite slave to pipelined Wishbone master, one transaction in flight,
// with read/write arbitration and a watchdog that aborts hung WB cycles.
module axil2wb_wdog_bridge
  import axil2wb_pkg::*;
#(
  parameter int C_AXI_DATA_WIDTH  = 32,
  parameter int C_AXI_ADDR_WIDTH  = 28,
  parameter int LGTIMEOUT         = 8,
  parameter int TIMEOUT_CYCLES    = 10,
  parameter bit OPT_ROUNDROBIN    = 1'b1,
  parameter bit OPT_ZEROSTRB_SKIP = 1'b1,
  parameter int LGERRCNT          = 16,
  localparam int DW      = C_AXI_DATA_WIDTH,
  localparam int AXILLSB = axilLsb(C_AXI_DATA_WIDTH),
  localparam int AW      = C_AXI_ADDR_WIDTH - AXILLSB
) (
  input  logic                        i_clk,
  input  logic                        i_axi_reset_n,
  input  logic                        i_axi_awvalid,
  output logic                        o_axi_awready,
  input  logic [C_AXI_ADDR_WIDTH-1:0] i_axi_awaddr,
  input  logic [2:0]                  i_axi_awprot,
  input  logic                        i_axi_wvalid,
  output logic                        o_axi_wready,
  input  logic [DW-1:0]               i_axi_wdata,
  input  logic [DW/8-1:0]             i_axi_wstrb,
  output logic                        o_axi_bvalid,
  input  logic                        i_axi_bready,
  output logic [1:0]                  o_axi_bresp,
  input  logic                        i_axi_arvalid,
  output logic                        o_axi_arready,
  input  logic [C_AXI_ADDR_WIDTH-1:0] i_axi_araddr,
  input  logic [2:0]                  i_axi_arprot,
  output logic                        o_axi_rvalid,
  input  logic                        i_axi_rready,
  output logic [DW-1:0]               o_axi_rdata,
  output logic [1:0]                  o_axi_rresp,
  output logic                        o_wb_cyc,
  output logic                        o_wb_stb,
  output logic                        o_wb_we,
  output logic [AW-1:0]               o_wb_addr,
  output logic [DW-1:0]               o_wb_data,
  output logic [DW/8-1:0]             o_wb_sel,
  input  logic                        i_wb_stall,
  input  logic                        i_wb_ack,
  input  logic                        i_wb_err,
  input  logic [DW-1:0]               i_wb_data,
  output logic                        o_timeout,
  output logic                        o_busy,
  output logic [LGERRCNT-1:0]         o_err_count
);

  state_e               state_q, state_d;
  logic                 cyc_q, cyc_d;
  logic                 stb_q, stb_d;
  logic                 we_q, we_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic [DW-1:0]        wdata_q, wdata_d;
  logic [DW/8-1:0]      sel_q, sel_d;
  logic [DW-1:0]        rdata_q, rdata_d;
  logic [1:0]           resp_q, resp_d;
  logic                 timeout_q, timeout_d;
  logic [LGERRCNT-1:0]  errCnt_q, errCnt_d;
  logic                 favorRead_q, favorRead_d;

  logic wrReq, rdReq, grantRead, grantWrite;
  logic expire, slvErr;
  logic unusedBits;

  assign unusedBits = ^{i_axi_awprot, i_axi_arprot,
                        i_axi_awaddr[AXILLSB-1:0], i_axi_araddr[AXILLSB-1:0]};

  // Readies are combinational so the AXI handshake lands on the same edge as the capture.
  assign wrReq      = i_axi_awvalid && i_axi_wvalid;
  assign rdReq      = i_axi_arvalid;
  assign grantRead  = i_axi_reset_n && (state_q == IDLE) && rdReq &&
                      (!wrReq || !OPT_ROUNDROBIN || favorRead_q);
  assign grantWrite = i_axi_reset_n && (state_q == IDLE) && wrReq && !grantRead;

  axil2wb_watchdog #(
    .LGTIMEOUT      (LGTIMEOUT),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk_i    (i_clk),
    .rst_ni   (i_axi_reset_n),
    .clear_i  (state_q == IDLE),
    .enable_i (cyc_q),
    .expire_o (expire)
  );

  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    stb_d       = stb_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    sel_d       = sel_q;
    rdata_d     = rdata_q;
    resp_d      = resp_q;
    timeout_d   = 1'b0;
    errCnt_d    = errCnt_q;
    favorRead_d = favorRead_q;
    slvErr      = 1'b0;

    case (state_q)
      IDLE: begin
        if (grantRead) begin
          favorRead_d = 1'b0;
          we_d        = 1'b0;
          addr_d      = i_axi_araddr[C_AXI_ADDR_WIDTH-1:AXILLSB];
          sel_d       = '1;
          cyc_d       = 1'b1;
          stb_d       = 1'b1;
          state_d     = BUS;
        end else if (grantWrite) begin
          favorRead_d = 1'b1;
          we_d        = 1'b1;
          addr_d      = i_axi_awaddr[C_AXI_ADDR_WIDTH-1:AXILLSB];
          wdata_d     = i_axi_wdata;
          sel_d       = i_axi_wstrb;
          if (OPT_ZEROSTRB_SKIP && (i_axi_wstrb == '0)) begin
            resp_d  = RESP_OKAY;
            state_d = BRESP;
          end else begin
            cyc_d   = 1'b1;
            stb_d   = 1'b1;
            state_d = BUS;
          end
        end
      end

      // Priority on termination: err over ack, and any slave answer over the watchdog.
      BUS, WAITACK: begin
        if (i_wb_err || i_wb_ack || expire) begin
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          state_d = we_q ? BRESP : RRESP;
          if (i_wb_err) begin
            resp_d = RESP_SLVERR;
            slvErr = 1'b1;
            if (!we_q) rdata_d = '0;
          end else if (i_wb_ack) begin
            resp_d = RESP_OKAY;
            if (!we_q) rdata_d = i_wb_data;
          end else begin
            resp_d    = RESP_SLVERR;
            slvErr    = 1'b1;
            timeout_d = 1'b1;
            if (!we_q) rdata_d = '0;
          end
        end else if ((state_q == BUS) && !i_wb_stall) begin
          stb_d   = 1'b0;
          state_d = WAITACK;
        end
      end

      BRESP: begin
        if (i_axi_bready) state_d = IDLE;
      end

      RRESP: begin
        if (i_axi_rready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    if (slvErr && (errCnt_q != '1)) begin
      errCnt_d = errCnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_axi_reset_n) begin
    if (!i_axi_reset_n) begin
      state_q     <= IDLE;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      sel_q       <= '0;
      rdata_q     <= '0;
      resp_q      <= RESP_OKAY;
      timeout_q   <= 1'b0;
      errCnt_q    <= '0;
      favorRead_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      stb_q       <= stb_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      sel_q       <= sel_d;
      rdata_q     <= rdata_d;
      resp_q      <= resp_d;
      timeout_q   <= timeout_d;
      errCnt_q    <= errCnt_d;
      favorRead_q <= favorRead_d;
    end
  end

  assign o_axi_awready = grantWrite;
  assign o_axi_wready  = grantWrite;
  assign o_axi_arready = grantRead;
  assign o_axi_bvalid  = (state_q == BRESP);
  assign o_axi_bresp   = resp_q;
  assign o_axi_rvalid  = (state_q == RRESP);
  assign o_axi_rdata   = rdata_q;
  assign o_axi_rresp   = resp_q;
  assign o_wb_cyc      = cyc_q;
  assign o_wb_stb      = stb_q;
  assign o_wb_we       = we_q;
  assign o_wb_addr     = addr_q;
  assign o_wb_data     = wdata_q;
  assign o_wb_sel      = sel_q;
  assign o_timeout     = timeout_q;
  assign o_busy        = (state_q != IDLE);
  assign o_err_count   = errCnt_q;

endmodule
